// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg
// Shared types for the multi-cycle ALU:
//   op_e        - 3-bit operation code presented on alu_mc.op
//   state_e     - top-level controller states
//   iter_mode_e - selects shift-add multiply or restoring divide in alu_iter_unit
//   ITER_CNT_W / iter_cnt_width() - iteration down-counter width, $clog2(WIDTH+1)
package alu_mc_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_MUL = 3'd4,
      OP_DIV = 3'd5,
      OP_REM = 3'd6,
      OP_XOR = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } iter_mode_e;

   localparam int DEFAULT_WIDTH = 16;

   // Counter must hold the value WIDTH itself, hence WIDTH+1.
   localparam int ITER_CNT_W = $clog2(DEFAULT_WIDTH + 1);

   function automatic int iter_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit
// Shared iterative engine for unsigned multiply (shift-add) and unsigned
// restoring divide, one bit per clock for WIDTH clocks.
//   clk, rst  - clock, async active-high reset
//   start     - load operands and begin (ignored while busy is implied by cnt)
//   mode      - MODE_MUL or MODE_DIV, latched on start
//   a, b      - MUL: multiplicand, multiplier; DIV: dividend, divisor
//   last      - the step executing on the coming edge is the final one
//   acc_nxt   - MUL: product after this step; DIV: remainder after this step
//   sreg_nxt  - DIV: quotient after this step
// The owner samples acc_nxt/sreg_nxt on the edge where last is high, so
// the final result is registered without an extra drain cycle.
module alu_iter_unit
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  iter_mode_e       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] acc_nxt,
   output logic [WIDTH-1:0] sreg_nxt
);

   localparam int CNT_W = iter_cnt_width(WIDTH);

   iter_mode_e       mode_q;
   logic [WIDTH-1:0] acc_q;    // MUL: partial product; DIV: partial remainder
   logic [WIDTH-1:0] sreg_q;   // MUL: multiplier (shifts right); DIV: dividend in / quotient out
   logic [WIDTH-1:0] opnd_q;   // MUL: multiplicand (shifts left); DIV: divisor
   logic [CNT_W-1:0] cnt_q;    // remaining steps, 0 when idle

   logic [WIDTH-1:0] opnd_nxt;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             q_bit;

   always_comb begin
      acc_nxt  = acc_q;
      sreg_nxt = sreg_q;
      opnd_nxt = opnd_q;
      shifted  = '0;
      diff     = '0;
      q_bit    = 1'b0;
      if (mode_q == MODE_MUL) begin
         // Only the low WIDTH bits of the product are kept, so the
         // multiplicand may be shifted out of range without harm.
         acc_nxt  = sreg_q[0] ? acc_q + opnd_q : acc_q;
         sreg_nxt = sreg_q >> 1;
         opnd_nxt = opnd_q << 1;
      end else begin
         // Bring in the next dividend bit; the shifted remainder is always
         // below 2*divisor so WIDTH+1 bits are enough for the trial.
         shifted = {acc_q, sreg_q[WIDTH-1]};
         diff    = shifted - {1'b0, opnd_q};
         q_bit   = (shifted >= {1'b0, opnd_q});
         acc_nxt  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         sreg_nxt = {sreg_q[WIDTH-2:0], q_bit};
      end
   end

   assign last = (cnt_q == CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= MODE_MUL;
         acc_q  <= '0;
         sreg_q <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
      end else if (start && (cnt_q == '0)) begin
         mode_q <= mode;
         acc_q  <= '0;
         sreg_q <= (mode == MODE_MUL) ? b : a;
         opnd_q <= (mode == MODE_MUL) ? a : b;
         cnt_q  <= CNT_W'(WIDTH);
      end else if (cnt_q != '0) begin
         acc_q  <= acc_nxt;
         sreg_q <= sreg_nxt;
         opnd_q <= opnd_nxt;
         cnt_q  <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_mc.sv
// alu_mc
// Multi-cycle ALU with valid/ready on both sides. ADD/SUB/AND/OR/XOR and
// divide-by-zero complete on the accept edge; MUL/DIV/REM iterate WIDTH
// clocks in alu_iter_unit. Result and flags are registered and held until
// the consumer takes them.
//   clk, rst     - clock, async active-high reset
//   in_valid     - operation presented on a, b, op
//   in_ready     - high only in IDLE (decoded from state)
//   a, b, op     - operands / opcode (op_e encoding), latched on accept
//   out_valid    - registered result available
//   out_ready    - consumer takes result
//   result       - operation result
//   cout         - carry out of MSB (ADD/SUB), 1 on SUB means no borrow
//   overflow     - signed overflow (ADD/SUB)
//   NO           - result MSB
//   ZO           - result is zero
//   div_by_zero  - DIV/REM issued with b == 0
//
// state   | meaning
// IDLE    | waiting for an operation, in_ready high
// MUL     | shift-add multiply in progress
// DIV     | restoring divide (DIV or REM) in progress
// DONE    | result held, out_valid high until out_ready
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             NO,
   output logic             ZO,
   output logic             div_by_zero
);

   state_e           state_q;
   logic             is_rem_q;
   op_e              op_in;
   logic             accept;
   logic             start_iter;
   iter_mode_e       iter_mode;

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sc_res;
   logic             sc_cout;
   logic             sc_ovf;
   logic             sc_dbz;

   logic             iter_last;
   logic [WIDTH-1:0] iter_acc;
   logic [WIDTH-1:0] iter_sreg;
   logic [WIDTH-1:0] iter_res;

   logic             capture;
   logic [WIDTH-1:0] cap_res;
   logic             cap_cout;
   logic             cap_ovf;
   logic             cap_dbz;

   assign op_in    = op_e'(op);
   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid && in_ready;

   assign start_iter = accept && ((op_in == OP_MUL) ||
                       (((op_in == OP_DIV) || (op_in == OP_REM)) && (b != '0)));
   assign iter_mode  = (op_in == OP_MUL) ? MODE_MUL : MODE_DIV;

   // Single-cycle datapath. SUB reuses the adder as a + ~b + 1, so cout
   // and overflow come out of the same expressions for both ops.
   always_comb begin
      b_eff   = (op_in == OP_SUB) ? ~b : b;
      sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_in == OP_SUB)};
      sc_res  = '0;
      sc_cout = 1'b0;
      sc_ovf  = 1'b0;
      sc_dbz  = 1'b0;
      case (op_in)
         OP_ADD, OP_SUB: begin
            sc_res  = sum[WIDTH-1:0];
            sc_cout = sum[WIDTH];
            sc_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: sc_res = a & b;
         OP_OR:  sc_res = a | b;
         OP_XOR: sc_res = a ^ b;
         // Only reached with b == 0; nonzero divisors go to the iterator.
         OP_DIV: begin
            sc_res = '1;
            sc_dbz = 1'b1;
         end
         OP_REM: begin
            sc_res = a;
            sc_dbz = 1'b1;
         end
         default: sc_res = '0;
      endcase
   end

   alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst      (rst),
      .start    (start_iter),
      .mode     (iter_mode),
      .a        (a),
      .b        (b),
      .last     (iter_last),
      .acc_nxt  (iter_acc),
      .sreg_nxt (iter_sreg)
   );

   assign iter_res = ((state_q == ST_DIV) && !is_rem_q) ? iter_sreg : iter_acc;

   // One capture path for both completion sources keeps the flag
   // derivation (NO/ZO) in a single place.
   always_comb begin
      capture  = 1'b0;
      cap_res  = iter_res;
      cap_cout = 1'b0;
      cap_ovf  = 1'b0;
      cap_dbz  = 1'b0;
      if (state_q == ST_IDLE) begin
         capture  = accept && !start_iter;
         cap_res  = sc_res;
         cap_cout = sc_cout;
         cap_ovf  = sc_ovf;
         cap_dbz  = sc_dbz;
      end else if ((state_q == ST_MUL) || (state_q == ST_DIV)) begin
         capture = iter_last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         is_rem_q    <= 1'b0;
         out_valid   <= 1'b0;
         result      <= '0;
         cout        <= 1'b0;
         overflow    <= 1'b0;
         NO          <= 1'b0;
         ZO          <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         if (capture) begin
            result      <= cap_res;
            cout        <= cap_cout;
            overflow    <= cap_ovf;
            NO          <= cap_res[WIDTH-1];
            ZO          <= (cap_res == '0);
            div_by_zero <= cap_dbz;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  is_rem_q <= (op_in == OP_REM);
                  if (start_iter) begin
                     state_q <= (iter_mode == MODE_MUL) ? ST_MUL : ST_DIV;
                  end else begin
                     state_q   <= ST_DONE;
                     out_valid <= 1'b1;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               if (iter_last) begin
                  state_q   <= ST_DONE;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q   <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;
   logic         NO;
   logic         ZO;
   logic         div_by_zero;

   int tests = 0;
   int fails = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .op          (op),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .cout        (cout),
      .overflow    (overflow),
      .NO          (NO),
      .ZO          (ZO),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model straight from the operation definitions.
   task automatic model(input int o, input int unsigned x, input int unsigned y,
                        output logic [W-1:0] r, output logic c, output logic v,
                        output logic z);
      int          sx;
      int          sy;
      int          s;
      longint unsigned p;
      sx = (x >= (1 << (W-1))) ? int'(x) - (1 << W) : int'(x);
      sy = (y >= (1 << (W-1))) ? int'(y) - (1 << W) : int'(y);
      r = '0; c = 1'b0; v = 1'b0; z = 1'b0;
      case (o)
         0: begin
            r = W'(x + y);
            c = ((x + y) >> W) != 0;
            s = sx + sy;
            v = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
         end
         1: begin
            r = W'(x - y);
            c = (x >= y);
            s = sx - sy;
            v = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
         end
         2: r = W'(x & y);
         3: r = W'(x | y);
         4: begin
            p = longint'(x) * longint'(y);
            r = W'(p);
         end
         5: if (y == 0) begin r = '1; z = 1'b1; end else r = W'(x / y);
         6: if (y == 0) begin r = W'(x); z = 1'b1; end else r = W'(x % y);
         default: r = W'(x ^ y);
      endcase
   endtask

   task automatic do_op(input int o, input int unsigned x, input int unsigned y,
                        input int hold, input string nm);
      logic [W-1:0] er;
      logic         ec;
      logic         ev;
      logic         ez;
      int           exp_lat;
      int           lat;
      int           guard;
      logic         rdy_seen;
      model(o, x, y, er, ec, ev, ez);
      exp_lat = ((o == 4) || (((o == 5) || (o == 6)) && (y != 0))) ? W + 1 : 1;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); @(negedge clk); guard++;
      end
      chk({nm, ".in_ready_idle"}, in_ready, 1);
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      op        = 3'(o);
      a         = W'(x);
      b         = W'(y);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      a  = W'($urandom);
      b  = W'($urandom);
      op = 3'($urandom);
      rdy_seen = in_ready;
      while (!out_valid && lat < 60) begin
         @(posedge clk); lat++; @(negedge clk);
         a = W'($urandom);
         b = W'($urandom);
         rdy_seen = rdy_seen | in_ready;
      end
      chk({nm, ".latency"}, lat, exp_lat);
      chk({nm, ".in_ready_busy"}, rdy_seen, 0);
      chk({nm, ".result"}, result, er);
      chk({nm, ".cout"}, cout, ec);
      chk({nm, ".overflow"}, overflow, ev);
      chk({nm, ".NO"}, NO, er[W-1]);
      chk({nm, ".ZO"}, ZO, (er == '0));
      chk({nm, ".div_by_zero"}, div_by_zero, ez);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         op = 3'($urandom);
         a  = W'($urandom);
         b  = W'($urandom);
         @(posedge clk); @(negedge clk);
         chk({nm, ".hold_result"}, result, er);
         chk({nm, ".hold_flags"}, {cout, overflow, NO, ZO, div_by_zero},
             {ec, ev, er[W-1], (er == '0), ez});
         chk({nm, ".hold_valid"}, out_valid, 1);
         chk({nm, ".hold_in_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk({nm, ".taken_valid"}, out_valid, 0);
      chk({nm, ".taken_in_ready"}, in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned x;
      int unsigned y;
      int          o;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; op = '0;
      #1 rst = 1'b1;
      #1;
      chk("reset.outputs", {out_valid, cout, overflow, NO, ZO, div_by_zero}, 0);
      chk("reset.result", result, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset.in_ready", in_ready, 1);
      chk("reset.out_valid", out_valid, 0);

      do_op(0, 32'h7FFF, 32'h0001, 0, "add_ovf");
      do_op(1, 32'h0005, 32'h0005, 0, "sub_eq");
      do_op(2, 32'hF0F0, 32'h0FF0, 0, "and");
      do_op(1, 32'h0003, 32'h0005, 0, "sub_borrow");
      do_op(1, 32'h8000, 32'h0001, 0, "sub_ovf");
      do_op(4, 300, 300, 0, "mul");
      do_op(5, 100, 7, 0, "div");
      do_op(6, 100, 7, 0, "rem");
      do_op(5, 32'h1234, 0, 0, "div0");
      do_op(6, 32'h1234, 0, 0, "rem0");
      do_op(4, 32'h1357, 32'h2468, 5, "mul_bp");
      do_op(7, 32'hAAAA, 32'hFFFF, 1, "xor_bp");

      // Abort a divide partway through with an asynchronous reset.
      do_op(0, 32'h7FFF, 32'h0001, 0, "add_pre_rst");
      in_valid = 1'b1; op = 3'd5; a = W'(1000); b = W'(7);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid.result", result, 0);
      chk("rst_mid.flags", {out_valid, cout, overflow, NO, ZO, div_by_zero}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid.in_ready", in_ready, 1);
      chk("rst_mid.out_valid", out_valid, 0);
      do_op(0, 2, 3, 0, "add_after_rst");

      for (int i = 0; i < 40; i++) begin
         o = int'($urandom_range(0, 7));
         x = $urandom_range(0, (1 << W) - 1);
         case ($urandom_range(0, 3))
            0: y = 0;
            1: y = $urandom_range(1, 15);
            default: y = $urandom_range(0, (1 << W) - 1);
         endcase
         do_op(o, x, y, int'($urandom_range(0, 2)), $sformatf("rand%0d_op%0d", i, o));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the 16-bit combinational ALU. Accepts one operation at a time over a valid/ready handshake, executes ADD/SUB/logic ops in one cycle and MUL/DIV/REM iteratively, and presents a registered result with flags. It sits between the decode/operand-fetch stage and writeback. Back-pressure is supported on both sides.

## Interface
Parameters:
- WIDTH, 16, operand/result width (≥4).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A (dividend for DIV/REM).
- b  in  WIDTH  operand B (divisor for DIV/REM).
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 DIV, 6 REM, 7 XOR.
- out_valid  out  1  result registered and held.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  operation result.
- cout  out  1  carry out (ADD/SUB only, else 0).
- overflow  out  1  signed overflow (ADD/SUB only, else 0).
- NO  out  1  result[WIDTH-1].
- ZO  out  1  result == 0.
- div_by_zero  out  1  DIV/REM with b == 0, else 0.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset → IDLE.
- Accept = in_valid & in_ready. On accept, a, b, op are latched; later changes to inputs are ignored.
- IDLE + accept of op 0/1/2/3/7 → DONE, result computed and registered the same edge.
- IDLE + accept of op 4 → MUL. Shift-add runs one bit per cycle for WIDTH cycles. Result = low WIDTH bits of a*b, unsigned. Then → DONE.
- IDLE + accept of op 5/6 with b ≠ 0 → DIV. Restoring division runs one bit per cycle for WIDTH cycles, unsigned. DIV gives the quotient, REM gives the remainder. Then → DONE.
- op 5/6 with b == 0 → DONE directly. DIV result = all ones; REM result = a; div_by_zero = 1.
- SUB = a + ~b + 1. cout = carry out of the MSB, so 1 means no borrow. overflow = operand signs equal (after inversion of b for SUB) and result sign differs.
- DONE: out_valid = 1. result and all flags are held stable until out_ready = 1. On out_valid & out_ready → IDLE.
- in_ready = (state == IDLE). No overlap: a new op is accepted only after the previous result is taken.
- Reset is asserted asynchronously, including mid-iteration. It aborts any operation and returns to IDLE. Reset values: result 0, cout 0, overflow 0, NO 0, ZO 0, div_by_zero 0, out_valid 0, in_ready 1 (once rst is released).

## Timing
- Single-cycle ops: accept at edge N → out_valid high after edge N+1, i.e. 1-cycle latency.
- MUL/DIV/REM: out_valid high after edge N+WIDTH+1.
- DIV/REM by zero: 1-cycle latency.
- With out_ready tied high, each op occupies its latency plus 1 cycle (the DONE handshake cycle). The next accept happens in the cycle after the handshake.
- All outputs are registered except in_ready, which is decoded from the state register.

## Structure
- Package alu_mc_pkg holds:
  - the op_e enum (ADD…XOR, 3 bits),
  - the state_e enum (IDLE, MUL, DIV, DONE),
  - the localparam for the iteration counter width, $clog2(WIDTH+1).
- One sub-module, alu_iter_unit, contains the shared shift register, accumulator and counter for MUL and DIV. It has a start/done interface and a mode input.
- The top level contains the FSM, the single-cycle datapath, the flag logic and the output registers.

## Test plan
All scenarios use WIDTH=16.
1. ADD a=0x7FFF, b=0x0001 → result 0x8000, overflow 1, NO 1, cout 0, ZO 0; out_valid exactly 1 cycle after accept.
2. SUB a=0x0005, b=0x0005 → result 0, ZO 1, cout 1, overflow 0; then AND 0xF0F0 & 0x0FF0 → 0x00F0, cout 0.
3. MUL 300*300 → result 0x5F90, out_valid 17 cycles after accept, in_ready low throughout; DIV 100/7 → 14; REM 100/7 → 2.
4. DIV 0x1234/0 → result 0xFFFF, div_by_zero 1, latency 1; REM 0x1234/0 → 0x1234.
5. Back-pressure: out_ready held low 5 cycles after out_valid → result and flags unchanged, in_ready 0, new in_valid ignored; a and b changed mid-MUL → result unaffected.
6. rst asserted at iteration 8 of a DIV → all outputs 0 immediately, in_ready 1 after release; a subsequent ADD 2+3 returns 5.
